freq_meas_ctrl: RTL
===================

Name: freq_meas_ctrl

Overview:
Auto-ranging sequencer for the frequency counter. It selects the prescaler ratio of the external pulse divider bank through div_sel and resets that bank on every range change. It counts divided edges over a fixed gate window of the system clock and moves the range up or down until the count lands between the thresholds. The final count and its range are then published with a one-cycle valid strobe.

Parameters:
GATE_CYCLES, 1000, gate window length in clk cycles (>=2)
CNT_W, 16, width of the edge counter and of result_count
SEL_W, 3, width of div_sel; divider ratio = 2^div_sel
MAX_SEL, 7, highest legal div_sel (<= 2^SEL_W-1)
HI_THRESH, 40000, count >= this steps the range up; must exceed 2*LO_THRESH
LO_THRESH, 10000, count < this steps the range down
SETTLE_CYCLES, 8, clk cycles waited after a range change before gating (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  request one measurement; sampled only in IDLE
continuous  in  1  1 = re-measure back-to-back; sampled in DONE
edge_in  in  1  divided pulse from the divider bank, asynchronous to clk
div_sel  out  SEL_W  prescaler select to the divider bank
div_rst  out  1  divider reset, high for 1 cycle on range change/start
busy  out  1  high in every state except IDLE
result_valid  out  1  one-cycle strobe, result fields updated same cycle
result_count  out  CNT_W  edges counted in final gate window
result_sel  out  SEL_W  div_sel used for result_count
overflow  out  1  result_count saturated

Behaviour:
- Reset (rst=0 at a clk edge), including mid-operation: state=IDLE; div_sel=0; div_rst=0; busy=0; result_valid=0; result_count=0; result_sel=0; overflow=0; counter, step budget and synchronizer cleared.
- edge_in passes through a 2-FF synchronizer plus a previous-value register. A rising edge is detected when sync=1 and prev=0. The latency from an edge_in rise to the counted event is 3 clk cycles. The maximum countable rate is clk/2.
- States: IDLE, SETTLE, GATE, EVAL, DONE.
- IDLE: busy=0. If start=1: go to SETTLE, pulse div_rst for the first SETTLE cycle, load step budget = MAX_SEL+1. div_sel keeps its last value and is 0 after reset.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. Detected edges are ignored. The counter is cleared. Then go to GATE.
- GATE: lasts exactly GATE_CYCLES cycles. Every detected edge increments the counter. The counter saturates at 2^CNT_W-1 and sets an internal sat flag. Then go to EVAL.
- EVAL (1 cycle):
  - If (count >= HI_THRESH or sat) and div_sel < MAX_SEL and budget > 0: div_sel+1, budget-1, go to SETTLE with div_rst pulse.
  - Else if count < LO_THRESH and div_sel > 0 and budget > 0: div_sel-1, budget-1, go to SETTLE with div_rst pulse.
  - Else go to DONE.
- Range limits: at div_sel=MAX_SEL with a high count, or at div_sel=0 with a low count, the result is published without a range change.
- Budget exhaustion: when budget=0, the result is published as-is. This bounds the latency with no hunting.
- DONE (1 cycle): result_valid=1; result_count=count; result_sel=div_sel; overflow=sat. If continuous=1, go to GATE with the counter cleared and budget reloaded; div_sel is unchanged and there is no settle. Otherwise go to IDLE.
- A start pulse while busy=1 is ignored. Results are held until the next DONE.
- Timing:
  - Single-range measurement from start sampled: SETTLE_CYCLES+GATE_CYCLES+2 cycles to result_valid.
  - Each range change adds SETTLE_CYCLES+GATE_CYCLES+1.
  - Continuous mode with a stable range: result_valid every GATE_CYCLES+2 cycles.
- Simultaneous events: a detected edge in the last GATE cycle is counted. An edge detected in EVAL/DONE/SETTLE is dropped.

Optional Feature:
Macro FMC_AUTORANGE_EN.
- Defined: auto-ranging as above.
- Undefined:
  - EVAL always goes to DONE.
  - div_sel is loaded from a SEL_W-bit input port range_sel on the IDLE->SETTLE transition. range_sel values above MAX_SEL are clamped to MAX_SEL.
  - The step budget logic is removed.
  - Port range_sel exists only in this build.

Test Plan:
Common bench setup: GATE_CYCLES=400, CNT_W=8, MAX_SEL=3, HI_THRESH=200, LO_THRESH=50, SETTLE_CYCLES=4. The bench models the divider as source/2^div_sel and re-phases it on div_rst.
1. Source period 4 clk, start -> one result_valid 406 cycles after start; result_count=100, result_sel=0, overflow=0.
2. Source period 2 clk -> first gate counts 200 and div_sel steps to 1 with a div_rst pulse; second gate gives result_count=100, result_sel=1, result_valid at cycle 811.
3. Source period 16 clk at div_sel=0 -> count 25 < LO but div_sel=0 -> published: result_count=25, result_sel=0.
4. Separate instance with MAX_SEL=0, GATE_CYCLES=600, source period 2 -> result_count=255, overflow=1, result_sel=0.
5. continuous=1 with source period 4 -> result_valid strobes exactly 402 cycles apart, each with count=100. Dropping continuous -> return to IDLE after the next DONE, busy=0.
6. rst=0 for 1 cycle mid-GATE in scenario 2 -> all outputs at reset values next cycle and div_sel=0. A new start then completes normally with a correct result.

Source files
------------

// File: rtl/freq_meas_ctrl_if.sv
// Control and result bundle between the frequency-counter sequencer, its user and the divider bank.
// range_sel is present only when FMC_AUTORANGE_EN is undefined (manual range build).
interface freq_meas_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int SEL_W = 3
);
  logic             start;
  logic             continuous;
  logic             edge_in;
`ifndef FMC_AUTORANGE_EN
  logic [SEL_W-1:0] range_sel;
`endif
  logic [SEL_W-1:0] div_sel;
  logic             div_rst;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] result_count;
  logic [SEL_W-1:0] result_sel;
  logic             overflow;

  modport master (
`ifndef FMC_AUTORANGE_EN
    output range_sel,
`endif
    output start, continuous, edge_in,
    input  div_sel, div_rst, busy, result_valid, result_count, result_sel, overflow
  );

  modport slave (
`ifndef FMC_AUTORANGE_EN
    input  range_sel,
`endif
    input  start, continuous, edge_in,
    output div_sel, div_rst, busy, result_valid, result_count, result_sel, overflow
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Auto-ranging gate-window frequency counter sequencer driving an external 2^div_sel divider bank.
// Macro FMC_AUTORANGE_EN enables range stepping; otherwise the range comes from range_sel.
module freq_meas_ctrl #(
  parameter int GATE_CYCLES   = 1000,
  parameter int CNT_W         = 16,
  parameter int SEL_W         = 3,
  parameter int MAX_SEL       = 7,
  parameter int HI_THRESH     = 40000,
  parameter int LO_THRESH     = 10000,
  parameter int SETTLE_CYCLES = 8
) (
  input logic             clk,
  input logic             rst,
  freq_meas_ctrl_if.slave bus
);
  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_MAX     = SEL_W'(MAX_SEL);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  if (GATE_CYCLES < 2) begin : g_bad_gate
    $error("freq_meas_ctrl: GATE_CYCLES must be >= 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("freq_meas_ctrl: SETTLE_CYCLES must be >= 1");
  end
  if (MAX_SEL > (2**SEL_W) - 1) begin : g_bad_max_sel
    $error("freq_meas_ctrl: MAX_SEL does not fit in SEL_W bits");
  end
  if (HI_THRESH <= 2 * LO_THRESH) begin : g_bad_thresh
    $error("freq_meas_ctrl: HI_THRESH must exceed 2*LO_THRESH");
  end

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, EVAL, DONE} state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic             sync1, sync2, prev, rise;
  logic [SEL_W-1:0] sel;
  logic             div_rst_q, res_valid_q, ovf_q;
  logic [CNT_W-1:0] res_count_q;
  logic [SEL_W-1:0] res_sel_q;
  logic             enter_settle, publish;

`ifdef FMC_AUTORANGE_EN
  localparam int BUDGET_W = $clog2(MAX_SEL + 2);
  localparam logic [BUDGET_W-1:0] BUDGET_INIT = BUDGET_W'(MAX_SEL + 1);

  logic [BUDGET_W-1:0] budget;
  logic                step_up, step_dn, rearm, hi, lo;

  // A saturated window is treated as "too fast" even if HI_THRESH exceeds the counter range.
  assign hi = (32'(count) >= 32'(HI_THRESH)) || sat;
  assign lo = 32'(count) < 32'(LO_THRESH);
`endif

  assign rise = sync2 & ~prev;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    enter_settle = 1'b0;
    publish      = 1'b0;
`ifdef FMC_AUTORANGE_EN
    step_up      = 1'b0;
    step_dn      = 1'b0;
    rearm        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt    = SETTLE;
          enter_settle = 1'b1;
`ifdef FMC_AUTORANGE_EN
          rearm        = 1'b1;
`endif
        end
      end
      SETTLE: if (tmr == SETTLE_LAST) state_nxt = GATE;
      GATE:   if (tmr == GATE_LAST)   state_nxt = EVAL;
      EVAL: begin
`ifdef FMC_AUTORANGE_EN
        if (hi && sel < SEL_MAX && budget != '0) begin
          step_up      = 1'b1;
          enter_settle = 1'b1;
          state_nxt    = SETTLE;
        end else if (lo && sel != '0 && budget != '0) begin
          step_dn      = 1'b1;
          enter_settle = 1'b1;
          state_nxt    = SETTLE;
        end else begin
          publish   = 1'b1;
          state_nxt = DONE;
        end
`else
        publish   = 1'b1;
        state_nxt = DONE;
`endif
      end
      DONE: begin
        if (bus.continuous) begin
          state_nxt = GATE;
`ifdef FMC_AUTORANGE_EN
          rearm     = 1'b1;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      prev        <= 1'b0;
      tmr         <= '0;
      count       <= '0;
      sat         <= 1'b0;
      sel         <= '0;
      div_rst_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_sel_q   <= '0;
      ovf_q       <= 1'b0;
`ifdef FMC_AUTORANGE_EN
      budget      <= '0;
`endif
    end else begin
      sync1       <= bus.edge_in;
      sync2       <= sync1;
      prev        <= sync2;
      div_rst_q   <= enter_settle;
      res_valid_q <= publish;

      if (state_nxt != state)                  tmr <= '0;
      else if (state == SETTLE || state == GATE) tmr <= tmr + 1'b1;

      // DONE clears too so a back-to-back gate starts from zero without a settle phase.
      if (state == SETTLE || state == DONE) begin
        count <= '0;
        sat   <= 1'b0;
      end else if (state == GATE && rise) begin
        if (count == CNT_MAX) sat   <= 1'b1;
        else                  count <= count + 1'b1;
      end

      if (publish) begin
        res_count_q <= count;
        res_sel_q   <= sel;
        ovf_q       <= sat;
      end

`ifdef FMC_AUTORANGE_EN
      if (step_up)      sel <= sel + 1'b1;
      else if (step_dn) sel <= sel - 1'b1;

      if (rearm)                   budget <= BUDGET_INIT;
      else if (step_up || step_dn) budget <= budget - 1'b1;
`else
      if (enter_settle) sel <= (bus.range_sel > SEL_MAX) ? SEL_MAX : bus.range_sel;
`endif
    end
  end

  assign bus.div_sel      = sel;
  assign bus.div_rst      = div_rst_q;
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = res_valid_q;
  assign bus.result_count = res_count_q;
  assign bus.result_sel   = res_sel_q;
  assign bus.overflow     = ovf_q;
endmodule
